alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for alu_seq.
// The BUSY state exists only when ALU_SEQ_MUL_EN is defined.
package alu_pkg;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;
  localparam logic [2:0] ALU_OP_ADC = 3'b010;
  localparam logic [2:0] ALU_OP_MUL = 3'b011;
  localparam logic [2:0] ALU_OP_AND = 3'b100;
  localparam logic [2:0] ALU_OP_OR  = 3'b101;
  localparam logic [2:0] ALU_OP_XOR = 3'b110;
  localparam logic [2:0] ALU_OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
    ST_BUSY = 2'd1,
`endif
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB) || (op == ALU_OP_ADC);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: start loads operands and applies
// partial product 0; WIDTH-1 further cycles follow, done pulses once with prod final.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   o_prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        // bit 0 of the multiplier is consumed on the start cycle so the
        // remaining WIDTH-1 bits finish exactly WIDTH cycles after start
        r_acc    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
        r_mcand  <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
        r_mplier <= {1'b0, i_b[WIDTH-1:1]};
        r_cnt    <= CW'(WIDTH-1);
      end else if (r_cnt != '0) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done   = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with IDLE/BUSY/DONE control and registered flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier and BUSY state.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             C_Out,
  output logic             Overflow,
  output logic             Negative
);

  alu_state_t       r_state;
  alu_state_t       w_state_next;

  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_cout;
  logic             r_ovf;
  logic             r_neg;
  logic             r_cf;

  logic [WIDTH-1:0] w_opb;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;

  logic             w_load;
  logic             w_cf_load;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

`ifdef ALU_SEQ_MUL_EN
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_mul_start),
    .i_a   (A),
    .i_b   (B),
    .done  (w_mul_done),
    .o_prod(w_prod)
  );
`endif

  // Single-cycle datapath; operands come straight from the ports at accept.
  always_comb begin
    w_opb = B;
    w_cin = 1'b0;
    case (S)
      ALU_OP_SUB: begin
        w_opb = ~B;
        w_cin = 1'b1;
      end
      ALU_OP_ADC: w_cin = r_cf;
      default: ;
    endcase
    w_sum = {1'b0, A} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};

    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (S)
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_ADC: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (A[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_OP_AND: w_alu_res = A & B;
      ALU_OP_OR:  w_alu_res = A | B;
      ALU_OP_XOR: w_alu_res = A ^ B;
      ALU_OP_NOT: w_alu_res = ~A;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_cf_load    = 1'b0;
    w_res        = w_alu_res;
    w_c          = w_alu_c;
    w_v          = w_alu_v;
`ifdef ALU_SEQ_MUL_EN
    w_mul_start  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          if (S == ALU_OP_MUL) begin
            w_state_next = ST_BUSY;
            w_mul_start  = 1'b1;
          end else begin
            w_state_next = ST_DONE;
            w_load       = 1'b1;
            w_cf_load    = is_arith(S);
          end
`else
          w_state_next = ST_DONE;
          w_load       = 1'b1;
          w_cf_load    = is_arith(S);
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_BUSY: begin
        if (w_mul_done) begin
          w_state_next = ST_DONE;
          w_load       = 1'b1;
          w_res        = w_prod[WIDTH-1:0];
          w_c          = |w_prod[2*WIDTH-1:WIDTH];
          w_v          = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_zero <= 1'b1;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_neg  <= 1'b0;
      r_cf   <= 1'b0;
    end else if (w_load) begin
      r_out  <= w_res;
      r_zero <= (w_res == '0);
      r_neg  <= w_res[WIDTH-1];
      r_cout <= w_c;
      r_ovf  <= w_v;
      if (w_cf_load) begin
        r_cf <= w_c;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign Out       = r_out;
  assign Zero      = r_zero;
  assign C_Out     = r_cout;
  assign Overflow  = r_ovf;
  assign Negative  = r_neg;

endmodule
